// File: rtl/ec_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ec_pkg: shared widths, counter init and FSM encoding for the renorm stage.
// Rev 1.0
// ----------------------------------------------------------------------------
package ec_pkg;

  localparam int LOW_W    = 32;
  localparam int WORD_W   = 9;
  localparam int CNT_INIT = -9;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ONE  = 2'd1,
    S_TWO  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ec_renorm_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ec_renorm_stage_if: symbol-update input, precarry output and state taps.
// Rev 1.0
// ----------------------------------------------------------------------------
interface ec_renorm_stage_if;
  import ec_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [15:0]             in_range;
  logic [15:0]             in_low_add;
  logic [15:0]             rng_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORD_W-1:0]       out_word;
  logic [LOW_W-1:0]        low_q;
  logic signed [CNT_W-1:0] cnt_q;
  logic                    err_range_zero;

  modport master (
    output in_valid, in_range, in_low_add, out_ready,
    input  in_ready, rng_out, out_valid, out_word, low_q, cnt_q, err_range_zero
  );

  modport slave (
    input  in_valid, in_range, in_low_add, out_ready,
    output in_ready, rng_out, out_valid, out_word, low_q, cnt_q, err_range_zero
  );

endinterface
`default_nettype wire

// File: rtl/lzc_miao_16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lzc_miao_16: 16-bit leading-zero counter built from nibble leaves.
// Rev 1.0   (v = 1 when the input is all zero; out_z is then don't-care)
// ----------------------------------------------------------------------------
module lzc_miao_16 (
  input  logic [15:0] a,
  output logic [3:0]  out_z,
  output logic        v
);

  logic [3:0]      nib_a;
  logic [3:0][1:0] nib_z;
  logic [1:0]      byte_a;
  logic [1:0][2:0] byte_z;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_nib
      logic [3:0] nib;
      assign nib      = a[4*g+3 -: 4];
      assign nib_a[g] = (nib == 4'd0);
      assign nib_z[g] = nib[3] ? 2'd0 : nib[2] ? 2'd1 : nib[1] ? 2'd2 : 2'd3;
    end

    for (genvar b = 0; b < 2; b++) begin : g_byte
      assign byte_a[b] = nib_a[2*b+1] & nib_a[2*b];
      assign byte_z[b] = nib_a[2*b+1] ? {1'b1, nib_z[2*b]} : {1'b0, nib_z[2*b+1]};
    end
  endgenerate

  assign v     = byte_a[1] & byte_a[0];
  assign out_z = byte_a[1] ? {1'b1, byte_z[0]} : {1'b0, byte_z[1]};

endmodule
`default_nettype wire

// File: rtl/ec_renorm_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ec_renorm_stage: AV1 entropy-encoder renormalization, emits 9-bit precarry
// words (bit 8 = carry) through a two-deep output stage. Rev 1.0
// ----------------------------------------------------------------------------
module ec_renorm_stage
  import ec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ec_renorm_stage_if.slave  bus
);

  state_e                  state_q, state_d;
  logic [15:0]             rng_q, rng_d;
  logic [LOW_W-1:0]        low_q, low_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [WORD_W-1:0]       skid_q, skid_d;
  logic                    err_q, err_d;

  logic [3:0]              lz;
  logic                    range_zero;
  logic                    accept;
  logic                    pop;

  logic [LOW_W-1:0]        sum;
  logic [5:0]              s;
  logic [4:0]              c;
  logic [4:0]              keep;
  logic [1:0]              n_emit;
  logic [LOW_W-1:0]        mask;
  logic [LOW_W-1:0]        low_next;
  logic [CNT_W-1:0]        cnt_next;
  logic [WORD_W-1:0]       word0, word1;

  lzc_miao_16 u_lzc (
    .a     (bus.in_range),
    .out_z (lz),
    .v     (range_zero)
  );

  assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_ONE) && bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = (state_q != S_IDLE) & bus.out_ready;

  // s stays within -9..14, so bit 5 is the sign and bit 3 separates 0..7 from 8..14.
  always_comb begin
    sum      = low_q + LOW_W'(bus.in_low_add);
    s        = {cnt_q[CNT_W-1], cnt_q} + {2'b00, lz};
    c        = 5'(cnt_q) + 5'd16;
    n_emit   = s[5] ? 2'd0 : (s[3] ? 2'd2 : 2'd1);
    keep     = (n_emit == 2'd2) ? (c - 5'd8) : c;
    mask     = (LOW_W'(1) << keep) - LOW_W'(1);
    word0    = WORD_W'(sum >> c);
    word1    = WORD_W'(sum >> (c - 5'd8));
    low_next = (n_emit == 2'd0) ? (sum << lz) : ((sum & mask) << lz);
    cnt_next = (n_emit == 2'd0) ? CNT_W'(s) :
               (n_emit == 2'd1) ? CNT_W'(s - 6'd8) : CNT_W'(s - 6'd16);
  end

  always_comb begin
    state_d = state_q;
    rng_d   = rng_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    skid_d  = skid_q;
    err_d   = err_q;

    if (pop) begin
      if (state_q == S_TWO) begin
        word_d  = skid_q;
        state_d = S_ONE;
      end else begin
        state_d = S_IDLE;
      end
    end

    // A legal accept only happens from an empty stage (idle, or popping its single word).
    if (accept) begin
      if (range_zero) begin
        err_d = 1'b1;
      end else begin
        rng_d = bus.in_range << lz;
        low_d = low_next;
        cnt_d = cnt_next;
        case (n_emit)
          2'd1: begin
            word_d  = word0;
            state_d = S_ONE;
          end
          2'd2: begin
            word_d  = word0;
            skid_d  = word1;
            state_d = S_TWO;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rng_q   <= 16'h8000;
      low_q   <= '0;
      cnt_q   <= CNT_W'(CNT_INIT);
      word_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rng_q   <= rng_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

  assign bus.rng_out        = rng_q;
  assign bus.out_valid      = (state_q != S_IDLE);
  assign bus.out_word       = word_q;
  assign bus.low_q          = low_q;
  assign bus.cnt_q          = cnt_q;
  assign bus.err_range_zero = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ec_renorm_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ec_renorm_stage: directed + random stimulus against an arithmetic model;
// expected words queued at issue time and consumed by an output monitor. Rev 1.0
// ----------------------------------------------------------------------------
module tb_ec_renorm_stage;
  import ec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ec_renorm_stage_if bus ();

  ec_renorm_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int mode   = 1;   // out_ready policy: 0 hold low, 1 hold high, 2 random

  logic [8:0] exp_q[$];
  longint     m_low;
  int         m_cnt;
  int         m_rng;
  bit         m_err;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_low = 0;
    m_cnt = -9;
    m_rng = 16'h8000;
    m_err = 1'b0;
    exp_q.delete();
  endfunction

  // Encoder renormalization rules in plain integer arithmetic.
  function automatic void model_apply(input logic [15:0] r, input logic [15:0] a);
    int     d;
    int     rr;
    int     s;
    int     c;
    longint sum;
    if (r == 16'd0) begin
      m_err = 1'b1;
      return;
    end
    rr = int'(r);
    d  = 0;
    while (rr < 32768) begin
      rr = rr * 2;
      d++;
    end
    sum = (m_low + longint'(a)) % (longint'(1) << 32);
    s   = m_cnt + d;
    if (s < 0) begin
      m_low = (sum << d) % (longint'(1) << 32);
      m_cnt = s;
    end else begin
      c = m_cnt + 16;
      exp_q.push_back(9'((sum >> c) % 512));
      if (s >= 8) begin
        exp_q.push_back(9'((sum >> (c - 8)) % 512));
        m_low = (sum % (longint'(1) << (c - 8))) << d;
        m_cnt = s - 16;
      end else begin
        m_low = (sum % (longint'(1) << c)) << d;
        m_cnt = s - 8;
      end
    end
    m_rng = rr;
  endfunction

  function automatic bit ready_exp();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready);
  endfunction

  task automatic set_ready(input int cyc, input int stall);
    if (cyc < stall || mode == 0) bus.out_ready = 1'b0;
    else if (mode == 1)           bus.out_ready = 1'b1;
    else                          bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_state();
    check("rng_out", longint'(bus.rng_out), longint'(m_rng));
    check("low_q", longint'(bus.low_q), m_low);
    check("cnt_q", longint'(bus.cnt_q), longint'(m_cnt));
    check("err_range_zero", longint'(bus.err_range_zero), longint'(m_err));
    check("out_valid", longint'(bus.out_valid), longint'(exp_q.size() != 0));
  endtask

  task automatic send(input logic [15:0] r, input logic [15:0] a, input int stall);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      set_ready(cyc, stall);
      bus.in_valid   = 1'b1;
      bus.in_range   = r;
      bus.in_low_add = a;
      #1;
      check("in_ready", longint'(bus.in_ready), longint'(ready_exp()));
      if (bus.in_ready) begin
        model_apply(r, a);
        done = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_state();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_ready(1, 0);
      bus.in_valid = 1'b0;
      #1;
      check("in_ready_idle", longint'(bus.in_ready), longint'(ready_exp()));
    end
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_rng_out", longint'(bus.rng_out), 64'h8000);
    check("rst_cnt_q", longint'(bus.cnt_q), -9);
    check("rst_low_q", longint'(bus.low_q), 0);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_err", longint'(bus.err_range_zero), 0);
    reset = 1'b1;
  endtask

  // Output monitor: whatever the stage presents must be the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word_unexpected: got 0x%0h expected no word", bus.out_word);
        end else begin
          check("out_word", longint'(bus.out_word), longint'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_range   = 16'h8000;
    bus.in_low_add = 16'h0;
    bus.out_ready  = 1'b0;
    do_reset();

    mode = 1;
    send(16'h8000, 16'h0000, 0);
    send(16'h0001, 16'hFFFF, 0);
    check("dir_low_one", longint'(bus.low_q), 64'h3F8000);
    check("dir_cnt_one", longint'(bus.cnt_q), -2);
    idle(2);

    mode = 0;
    send(16'h0001, 16'h0000, 0);
    check("dir_low_two", longint'(bus.low_q), 0);
    check("dir_cnt_two", longint'(bus.cnt_q), -3);
    idle(3);
    mode = 1;
    idle(3);

    mode = 0;
    send(16'h0100, 16'h1234, 0);
    mode = 1;
    send(16'h0010, 16'h00AB, 5);
    check("dir_pop_accept_valid", longint'(bus.out_valid), 1);
    idle(3);

    send(16'h0000, 16'h0055, 0);
    check("dir_err_set", longint'(bus.err_range_zero), 1);
    idle(2);

    do_reset();
    mode = 1;
    send(16'h0001, 16'hFFFF, 0);
    idle(2);
    mode = 0;
    send(16'h0001, 16'h0000, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", longint'(bus.out_valid), 0);
    check("async_rst_rng", longint'(bus.rng_out), 64'h8000);
    check("async_rst_cnt", longint'(bus.cnt_q), -9);
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    mode = 2;
    for (int i = 0; i < 400; i++) begin
      int          sh;
      logic [15:0] r;
      sh = $urandom_range(0, 15);
      r  = 16'($urandom_range(1, 65535) >> sh);
      if (r == 16'd0) r = 16'd1;
      send(r, 16'($urandom), 0);
    end

    mode = 1;
    idle(6);
    check("drain_empty", longint'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
